move_walker: RTL and testbench
==============================

# move_walker

Upstream sequencer for the chess move-generator core. It drives the core's 8-bit command/data bus and reads its 8-bit result byte. It enumerates every pseudo-legal move of the side to move in most-valuable-victim / least-valuable-aggressor order, issuing FIND-DST, FIND-SRC, SET-ENABLE, ENABLE-ALL and ENABLE-FRIENDLY. Each move is emitted as a (src, dst) pair over a valid/ready handshake to the search logic.

## Interface
Parameters:
- `RSP_LAT`, default 9: cycles from the cycle a FIND command is driven to the cycle its result byte is valid on `rsp`.

Ports:
- `clk`  in  1  clock; one clock domain; every register updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin enumeration; honoured only in IDLE.
- `abort`  in  1  return to IDLE at the next edge, from any state.
- `cmd_addr`  out  8  command byte to the core (registered).
- `cmd_data`  out  8  data byte to the core (registered).
- `rsp`  in  8  core result: [7] illegal (sticky), [6] none-found, [5:0] square.
- `move_valid`  out  1  `move_src`/`move_dst` hold a move.
- `move_ready`  in  1  consumer accepts the move.
- `move_src`  out  6  source square.
- `move_dst`  out  6  destination square.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of enumeration.
- `illegal`  out  1  valid with `done`: the position allows a king capture.
- `move_count`  out  8  moves emitted since `start`; saturates at 255.

## Operation
- Command encodings: ENABLE-ALL is `0xC0`/`0x00`. FIND-DST is `0xE0`/`0x00`. FIND-SRC is `{6'b111100, dst[5:4]}` with `{dst[3:0], 4'h0}`. SET-ENABLE(sq,0) is `{6'b110100, sq[5:4]}` with `{sq[3:0], 4'h0}`. ENABLE-FRIENDLY is `0x80`/`0x00`. NO-OP is `0x00`/`0x00`.
- A command is held for exactly one cycle. `cmd_addr`/`cmd_data` = NO-OP in every other cycle.
- FSM states: IDLE, EN_ALL, DST_CMD, DST_WAIT, SRC_CMD, SRC_WAIT, EMIT, KILL_SRC, KILL_DST, REFILL, FINISH.
- IDLE, `start` high → EN_ALL. `move_count` clears to 0 on this transition.
- EN_ALL: drive ENABLE-ALL → DST_CMD.
- DST_CMD: drive FIND-DST → DST_WAIT. A wait counter loads RSP_LAT-1.
- DST_WAIT, when the counter reaches 0, sample `rsp`:
  - `rsp[7]` set on the first FIND-DST after `start`: set `illegal`, go to FINISH.
  - Otherwise, `rsp[6]` set: go to FINISH.
  - Otherwise: latch `move_dst` = `rsp[5:0]`, go to SRC_CMD.
- SRC_CMD: drive FIND-SRC(`move_dst`) → SRC_WAIT.
- SRC_WAIT, on sample:
  - `rsp[6]` set: go to KILL_DST.
  - Otherwise: latch `move_src` = `rsp[5:0]`, go to EMIT.
  - `rsp[7]` is ignored here.
- EMIT: `move_valid` high. When `move_ready` is high, increment `move_count` (saturating) and go to KILL_SRC.
- KILL_SRC: drive SET-ENABLE(`move_src`,0) → SRC_CMD.
- KILL_DST: drive SET-ENABLE(`move_dst`,0) → REFILL.
- REFILL: drive ENABLE-FRIENDLY. This restores the source squares killed for this dst; victim squares stay disabled. Then → DST_CMD.
- FINISH: pulse `done` → IDLE. `illegal` holds its value until the next `start`.
- `abort` or `rst` mid-wait: the core may still be scanning. Before issuing any command after leaving IDLE, the walker waits RSP_LAT cycles from its last FIND. A 4-bit holdoff counter, loaded when a FIND is driven, enforces this.

## Timing
- Reset values:
  - `cmd_addr` = `cmd_data` = 0.
  - `move_valid` = `busy` = `done` = `illegal` = 0.
  - `move_src` = `move_dst` = 0.
  - `move_count` = 0.
  - FSM in IDLE; holdoff counter = RSP_LAT.
- `start` sampled high at the edge ending cycle T gives ENABLE-ALL on the bus in cycle T+1 and FIND-DST in T+2. `rsp` is sampled in T+2+RSP_LAT.
- `move_valid` rises in the cycle after the SRC_WAIT sample. Handshake completes at the edge where `move_valid` and `move_ready` are both high. `move_src`/`move_dst` are stable while `move_valid` is high.
- Steady-state cost per move is RSP_LAT+3 cycles with `move_ready` tied high.
- `abort` has priority over all transitions. `start` is ignored when `busy` is high.

## Structure
- Shared package `chess_pkg`: command opcodes (`CMD_FIND_SRC`, `CMD_FIND_DST`, `CMD_SET_EN`, `CMD_EN_ALL`, `CMD_EN_FRIENDLY`, `CMD_NOP`), result-bit positions (`RSP_ILLEGAL`=7, `RSP_NONE`=6), square type (6 bits), FSM state enum.
- Sub-module `cmd_encoder`: combinational (opcode, square) → (`cmd_addr`, `cmd_data`), registered in `move_walker`.

## Test plan
- Reset: hold `rst` 2 cycles. All outputs 0; `start` during `rst` is ignored.
- Empty enumeration: `start` in cycle 0; bench model returns `rsp`=`0x40`. Required bus sequence is `0xC0` in cycle 1, then `0xE0` in cycle 2. `done` pulses in cycle 12, `move_count`=0, `illegal`=0.
- One capture:
  - FIND-DST returns `0x1C` (e4), then `0x40`.
  - FIND-SRC(e4) returns `0x0B` (d2), then `0x40`.
  - Required response: exactly one move, src=`0x0B`, dst=`0x1C`.
  - Bus then shows SET-ENABLE d2 = `0xD0`/`0xB0`, FIND-SRC `0xF1`/`0xC0`, SET-ENABLE e4 = `0xD1`/`0xC0`, `0x80`, `0xE0`.
  - `move_count`=1.
- Backpressure: hold `move_ready` low 20 cycles in EMIT. `move_valid` stays high and src/dst are stable. No command other than NO-OP is issued until the handshake.
- Illegal: first FIND-DST returns `0xA5`. Required response: `done` with `illegal`=1, no moves, no FIND-SRC issued.
- Abort: assert `abort` 3 cycles after FIND-SRC. FSM goes to IDLE next edge, `move_valid`=0. A following `start` delays ENABLE-ALL until RSP_LAT cycles after that FIND-SRC.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared definitions for the move-generator sequencer.
// Contents:
//   square_t   - 6-bit board square index
//   cmd_op_e   - abstract command opcodes, turned into bus bytes by cmd_encoder
//   state_e    - move_walker FSM states
//   RSP_*      - bit positions inside the core's result byte
//   is_find()  - true for the commands that start a core scan
package chess_pkg;

    typedef logic [5:0] square_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_EN_ALL,
        CMD_FIND_DST,
        CMD_FIND_SRC,
        CMD_SET_EN,
        CMD_EN_FRIENDLY
    } cmd_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EN_ALL,
        ST_DST_CMD,
        ST_DST_WAIT,
        ST_SRC_CMD,
        ST_SRC_WAIT,
        ST_EMIT,
        ST_KILL_SRC,
        ST_KILL_DST,
        ST_REFILL,
        ST_FINISH
    } state_e;

    localparam int RSP_ILLEGAL = 7;
    localparam int RSP_NONE    = 6;

    // Bus bytes; the square-carrying commands put sq[5:4] in the low
    // address bits and sq[3:0] in the data high nibble.
    localparam logic [7:0] ADDR_EN_ALL      = 8'hC0;
    localparam logic [7:0] ADDR_FIND_DST    = 8'hE0;
    localparam logic [7:0] ADDR_EN_FRIENDLY = 8'h80;
    localparam logic [5:0] PFX_FIND_SRC     = 6'b111100;
    localparam logic [5:0] PFX_SET_EN       = 6'b110100;

    function automatic logic is_find(input cmd_op_e op);
        return (op == CMD_FIND_DST) || (op == CMD_FIND_SRC);
    endfunction

endpackage

// File: rtl/move_walker_cmd_encoder.sv
// cmd_encoder: combinational translation of (opcode, square) into the
// core's command address/data bytes.
// Ports:
//   i_op   in  3  opcode (chess_pkg::cmd_op_e value)
//   i_sq   in  6  square operand for FIND-SRC / SET-ENABLE
//   o_addr out 8  command address byte
//   o_data out 8  command data byte
module cmd_encoder
    import chess_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic [5:0] i_sq,
    output logic [7:0] o_addr,
    output logic [7:0] o_data
);

    always_comb begin
        o_addr = 8'h00;
        o_data = 8'h00;
        case (cmd_op_e'(i_op))
            CMD_EN_ALL:      o_addr = ADDR_EN_ALL;
            CMD_FIND_DST:    o_addr = ADDR_FIND_DST;
            CMD_EN_FRIENDLY: o_addr = ADDR_EN_FRIENDLY;
            CMD_FIND_SRC: begin
                o_addr = {PFX_FIND_SRC, i_sq[5:4]};
                o_data = {i_sq[3:0], 4'h0};
            end
            CMD_SET_EN: begin
                o_addr = {PFX_SET_EN, i_sq[5:4]};
                o_data = {i_sq[3:0], 4'h0};
            end
            default: begin
                o_addr = 8'h00;
                o_data = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/move_walker.sv
// move_walker: drives the move-generator core to enumerate every
// pseudo-legal move in MVV/LVA order and hands each (src, dst) pair to the
// search logic.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, abort          begin enumeration (IDLE only) / return to IDLE
//   cmd_addr, cmd_data    registered command bytes to the core
//   rsp                   core result: [7] illegal, [6] none-found, [5:0] square
//   move_valid/ready      move handshake; move_src/move_dst hold the move
//   busy, done, illegal   status; illegal is valid with done
//   move_count            moves emitted since start, saturating at 255
//   dbg_state             current FSM state (chess_pkg::state_e)
// Handshake: a move transfers at the rising edge where move_valid and
// move_ready are both high; move_src/move_dst do not change while
// move_valid is high, and move_valid never drops before that edge.
module move_walker
    import chess_pkg::*;
#(
    parameter int RSP_LAT = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    input  logic [7:0] rsp,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [5:0] move_src,
    output logic [5:0] move_dst,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic [7:0] move_count,
    output logic [3:0] dbg_state
);

    localparam logic [3:0] HOLD_INIT = 4'(RSP_LAT);
    localparam logic [3:0] WAIT_INIT = 4'(RSP_LAT - 1);

    state_e     r_state;
    cmd_op_e    r_op;          // command currently on the bus
    logic [7:0] r_cmd_addr;
    logic [7:0] r_cmd_data;
    logic [3:0] r_wait;
    logic [3:0] r_holdoff;     // cycles until the last FIND's scan is over
    logic       r_first_dst;
    square_t    r_move_src;
    square_t    r_move_dst;
    logic       r_move_valid;
    logic       r_busy;
    logic       r_done;
    logic       r_illegal;
    logic [7:0] r_move_count;

    state_e     w_state_n;
    cmd_op_e    w_op_n;
    square_t    w_sq_n;
    square_t    w_src_n;
    square_t    w_dst_n;
    logic       w_ill_n;
    logic       w_first_n;
    logic [7:0] w_count_n;
    logic [7:0] w_addr_n;
    logic [7:0] w_data_n;
    logic       w_hold_ok;
    logic       w_sample;

    // A value of 1 here means the scan ends during the cycle being
    // scheduled, so a command may already occupy that cycle.
    assign w_hold_ok = (r_holdoff <= 4'd1);
    assign w_sample  = (r_wait == 4'd0);

    // Next state and the command for the next cycle. The command is
    // registered together with the state, so the bus always shows the
    // command belonging to the state it is in.
    always_comb begin
        w_state_n = r_state;
        w_op_n    = CMD_NOP;
        w_sq_n    = r_move_dst;
        w_src_n   = r_move_src;
        w_dst_n   = r_move_dst;
        w_ill_n   = r_illegal;
        w_first_n = r_first_dst;
        w_count_n = r_move_count;
        if (abort) begin
            w_state_n = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_n = ST_EN_ALL;
                        w_count_n = 8'd0;
                        w_ill_n   = 1'b0;
                        w_first_n = 1'b1;
                        if (w_hold_ok) w_op_n = CMD_EN_ALL;
                    end
                end
                // Stays here issuing NO-OP until an aborted scan has drained.
                ST_EN_ALL: begin
                    if (r_op == CMD_EN_ALL) begin
                        w_state_n = ST_DST_CMD;
                        w_op_n    = CMD_FIND_DST;
                    end else if (w_hold_ok) begin
                        w_op_n = CMD_EN_ALL;
                    end
                end
                ST_DST_CMD: w_state_n = ST_DST_WAIT;
                ST_DST_WAIT: begin
                    if (w_sample) begin
                        w_first_n = 1'b0;
                        if (r_first_dst && rsp[RSP_ILLEGAL]) begin
                            w_ill_n   = 1'b1;
                            w_state_n = ST_FINISH;
                        end else if (rsp[RSP_NONE]) begin
                            w_state_n = ST_FINISH;
                        end else begin
                            w_dst_n   = rsp[5:0];
                            w_sq_n    = rsp[5:0];
                            w_state_n = ST_SRC_CMD;
                            w_op_n    = CMD_FIND_SRC;
                        end
                    end
                end
                ST_SRC_CMD: w_state_n = ST_SRC_WAIT;
                ST_SRC_WAIT: begin
                    if (w_sample) begin
                        if (rsp[RSP_NONE]) begin
                            w_state_n = ST_KILL_DST;
                            w_op_n    = CMD_SET_EN;
                            w_sq_n    = r_move_dst;
                        end else begin
                            w_src_n   = rsp[5:0];
                            w_state_n = ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (move_ready) begin
                        if (r_move_count != 8'hFF) w_count_n = r_move_count + 8'd1;
                        w_state_n = ST_KILL_SRC;
                        w_op_n    = CMD_SET_EN;
                        w_sq_n    = r_move_src;
                    end
                end
                ST_KILL_SRC: begin
                    w_state_n = ST_SRC_CMD;
                    w_op_n    = CMD_FIND_SRC;
                    w_sq_n    = r_move_dst;
                end
                ST_KILL_DST: begin
                    w_state_n = ST_REFILL;
                    w_op_n    = CMD_EN_FRIENDLY;
                end
                ST_REFILL: begin
                    w_state_n = ST_DST_CMD;
                    w_op_n    = CMD_FIND_DST;
                end
                ST_FINISH: w_state_n = ST_IDLE;
                default:   w_state_n = ST_IDLE;
            endcase
        end
    end

    cmd_encoder u_cmd_encoder (
        .i_op   (w_op_n),
        .i_sq   (w_sq_n),
        .o_addr (w_addr_n),
        .o_data (w_data_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= CMD_NOP;
            r_cmd_addr   <= 8'h00;
            r_cmd_data   <= 8'h00;
            r_wait       <= 4'd0;
            r_holdoff    <= HOLD_INIT;
            r_first_dst  <= 1'b0;
            r_move_src   <= 6'd0;
            r_move_dst   <= 6'd0;
            r_move_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
            r_move_count <= 8'd0;
        end else begin
            r_state      <= w_state_n;
            r_op         <= w_op_n;
            r_cmd_addr   <= w_addr_n;
            r_cmd_data   <= w_data_n;
            r_first_dst  <= w_first_n;
            r_move_src   <= w_src_n;
            r_move_dst   <= w_dst_n;
            r_move_valid <= (w_state_n == ST_EMIT);
            r_busy       <= (w_state_n != ST_IDLE);
            r_done       <= (w_state_n == ST_FINISH);
            r_illegal    <= w_ill_n;
            r_move_count <= w_count_n;
            // Wait counter starts at RSP_LAT-1 in the first wait cycle so
            // the sample lands exactly RSP_LAT cycles after the FIND.
            if (r_state == ST_DST_CMD || r_state == ST_SRC_CMD)
                r_wait <= WAIT_INIT;
            else if (r_wait != 4'd0)
                r_wait <= r_wait - 4'd1;
            if (is_find(w_op_n))
                r_holdoff <= HOLD_INIT;
            else if (r_holdoff != 4'd0)
                r_holdoff <= r_holdoff - 4'd1;
        end
    end

    assign cmd_addr   = r_cmd_addr;
    assign cmd_data   = r_cmd_data;
    assign move_valid = r_move_valid;
    assign move_src   = r_move_src;
    assign move_dst   = r_move_dst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign illegal    = r_illegal;
    assign move_count = r_move_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_move_walker.sv
// Bench for move_walker: a behavioural core model answers FIND commands
// from a list of victims and their attackers; expected moves come from
// walking that list in order.
module tb_move_walker;

    localparam int RSP_LAT = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [7:0] rsp;
    logic       move_valid;
    logic       move_ready;
    logic [5:0] move_src;
    logic [5:0] move_dst;
    logic       busy;
    logic       done;
    logic       illegal;
    logic [7:0] move_count;
    logic [3:0] dbg_state;

    move_walker #(.RSP_LAT(RSP_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rsp        (rsp),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_src   (move_src),
        .move_dst   (move_dst),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal),
        .move_count (move_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scenario and core model ----------------
    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } bus_t;

    typedef struct {
        int         due;
        logic [7:0] val;
    } pend_t;

    int          cyc = 0;
    bus_t        trace_q[$];
    pend_t       pend_q[$];
    logic [5:0]  vic[8];
    int          vic_n;
    logic [5:0]  att[64][4];
    int          att_n[64];
    logic [63:0] friendly;
    logic [63:0] en;
    logic        pos_ill;
    logic        first_dst;

    function automatic logic [7:0] find_dst();
        logic b7;
        b7 = first_dst ? pos_ill : 1'($urandom_range(0, 1));
        for (int i = 0; i < vic_n; i++)
            if (en[vic[i]]) return {b7, 1'b0, vic[i]};
        return {b7, 1'b1, 6'd0};
    endfunction

    function automatic logic [7:0] find_src(input logic [5:0] d);
        logic b7;
        b7 = 1'($urandom_range(0, 1));
        for (int j = 0; j < att_n[d]; j++)
            if (en[att[d][j]]) return {b7, 1'b0, att[d][j]};
        return {b7, 1'b1, 6'd0};
    endfunction

    // Core model: samples the bus just after each rising edge, keeps the
    // enable set, and places each FIND answer on rsp RSP_LAT cycles later.
    // Any other cycle carries random junk on rsp.
    initial begin
        pend_t p;
        logic [5:0] sq;
        rsp = 8'h00;
        en = '1;
        first_dst = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            rsp = 8'($urandom);
            while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                if (pend_q[0].due == cyc) rsp = pend_q[0].val;
                pend_q.delete(0);
            end
            if (cmd_addr != 8'h00 || cmd_data != 8'h00)
                trace_q.push_back('{c: cyc, a: cmd_addr, d: cmd_data});
            sq = {cmd_addr[1:0], cmd_data[7:4]};
            if (cmd_addr == 8'hC0) begin
                en = '1;
                first_dst = 1'b1;
            end else if (cmd_addr == 8'hE0) begin
                p.due = cyc + RSP_LAT;
                p.val = find_dst();
                pend_q.push_back(p);
                first_dst = 1'b0;
            end else if (cmd_addr[7:2] == 6'b111100) begin
                p.due = cyc + RSP_LAT;
                p.val = find_src(sq);
                pend_q.push_back(p);
            end else if (cmd_addr[7:2] == 6'b110100) begin
                en[sq] = 1'b0;
            end else if (cmd_addr == 8'h80) begin
                en = en | friendly;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    int          exp_n;
    logic        exp_ill;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_scn();
        vic_n = 0;
        for (int i = 0; i < 64; i++) att_n[i] = 0;
        friendly = '0;
        pos_ill = 1'b0;
    endtask

    task automatic add_att(input logic [5:0] v, input logic [5:0] a);
        att[v][att_n[v]] = a;
        att_n[v]++;
        friendly[a] = 1'b1;
    endtask

    // Every attacker of every victim, victims in priority order.
    task automatic build_expect();
        exp_q.delete();
        exp_ill = pos_ill;
        if (!pos_ill)
            for (int i = 0; i < vic_n; i++)
                for (int j = 0; j < att_n[vic[i]]; j++)
                    exp_q.push_back({att[vic[i]][j], vic[i]});
        exp_n = exp_q.size();
    endtask

    task automatic gen_random();
        logic [63:0] used;
        logic [5:0]  sq;
        int          na;
        clear_scn();
        used = '0;
        vic_n = $urandom_range(0, 4);
        for (int i = 0; i < vic_n; i++) begin
            do sq = 6'($urandom_range(32, 63)); while (used[sq]);
            used[sq] = 1'b1;
            vic[i] = sq;
            na = $urandom_range(0, 3);
            for (int j = 0; j < na; j++) begin
                logic dup;
                do begin
                    sq = 6'($urandom_range(0, 31));
                    dup = 1'b0;
                    for (int k = 0; k < att_n[vic[i]]; k++)
                        if (att[vic[i]][k] == sq) dup = 1'b1;
                end while (dup);
                add_att(vic[i], sq);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(output int s);
        trace_q.delete();
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs until done (bounded). mode 0: random ready and stray starts;
    // mode 1: ready held low for the first 20 cycles of each move.
    task automatic walk(input int mode, output int done_cyc, output int first_valid);
        int         waited;
        int         held;
        logic       pv;
        logic [5:0] ps;
        logic [5:0] pd;
        waited = 0;
        held = 0;
        pv = 1'b0;
        ps = 6'd0;
        pd = 6'd0;
        first_valid = -1;
        done_cyc = -1;
        while (!done && waited < 3000) begin
            start = (mode == 0 && busy && $urandom_range(0, 7) == 0);
            if (move_valid) begin
                if (first_valid < 0) first_valid = cyc;
                chk("bus_nop_while_valid", {cmd_addr, cmd_data}, 16'h0000);
                if (pv) begin
                    chk("src_stable", move_src, ps);
                    chk("dst_stable", move_dst, pd);
                end
                move_ready = (mode == 1) ? (held >= 20) : ($urandom_range(0, 3) != 0);
                if (move_ready) begin
                    if (exp_q.size() == 0) chk("extra_move", {move_src, move_dst}, 12'hFFF);
                    else chk("move", {move_src, move_dst}, exp_q.pop_front());
                    pv = 1'b0;
                    held = 0;
                end else begin
                    pv = 1'b1;
                    ps = move_src;
                    pd = move_dst;
                    held++;
                end
            end else begin
                move_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        move_ready = 1'b0;
        chk("done_seen", done, 1'b1);
        if (done) begin
            done_cyc = cyc;
            chk("illegal_at_done", illegal, exp_ill);
            chk("move_count", move_count, exp_n);
            chk("moves_missing", exp_q.size(), 0);
            @(negedge clk);
            chk("done_pulse_end", done, 1'b0);
            chk("idle_after_done", busy, 1'b0);
        end else begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            repeat (RSP_LAT + 2) @(negedge clk);
        end
    endtask

    task automatic chk_bus(input string tag, input int idx, input logic [15:0] exp_ad, input int exp_c);
        if (idx < trace_q.size()) begin
            chk({tag, "_bytes"}, {trace_q[idx].a, trace_q[idx].d}, exp_ad);
            if (exp_c >= 0) chk({tag, "_cycle"}, trace_q[idx].c, exp_c);
        end else begin
            chk({tag, "_missing"}, trace_q.size(), idx + 1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s;
        int dc;
        int fv;
        int f;
        int n_src;
        int waited;
        logic [15:0] cap_bus[8];

        rst = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        move_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_addr", cmd_addr, 8'h00);
        chk("rst_cmd_data", cmd_data, 8'h00);
        chk("rst_move_valid", move_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_move_src", move_src, 6'd0);
        chk("rst_move_dst", move_dst, 6'd0);
        chk("rst_move_count", move_count, 8'd0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("start_in_rst_ignored", busy, 1'b0);
        repeat (RSP_LAT + 3) @(negedge clk);

        // Empty enumeration
        clear_scn();
        build_expect();
        do_start(s);
        walk(0, dc, fv);
        chk_bus("empty_en_all", 0, 16'hC000, s + 1);
        chk_bus("empty_find_dst", 1, 16'hE000, s + 2);
        chk("empty_cmd_total", trace_q.size(), 2);
        chk("empty_done_cycle", dc, s + RSP_LAT + 3);

        // One capture with 20 cycles of backpressure
        clear_scn();
        vic_n = 1;
        vic[0] = 6'h1C;
        add_att(6'h1C, 6'h0B);
        build_expect();
        do_start(s);
        walk(1, dc, fv);
        cap_bus = '{16'hC000, 16'hE000, 16'hF1C0, 16'hD0B0,
                    16'hF1C0, 16'hD1C0, 16'h8000, 16'hE000};
        for (int i = 0; i < 8; i++) chk_bus("capture_bus", i, cap_bus[i], -1);
        chk("capture_cmd_total", trace_q.size(), 8);
        if (trace_q.size() >= 4) begin
            chk("capture_find_src_cycle", trace_q[2].c, trace_q[1].c + RSP_LAT + 1);
            chk("capture_valid_rise", fv, trace_q[2].c + RSP_LAT + 1);
            chk("capture_kill_after_hs", trace_q[3].c, fv + 21);
        end

        // Illegal position
        clear_scn();
        vic_n = 1;
        vic[0] = 6'h25;
        add_att(6'h25, 6'h03);
        pos_ill = 1'b1;
        build_expect();
        do_start(s);
        walk(0, dc, fv);
        n_src = 0;
        foreach (trace_q[i]) if (trace_q[i].a[7:2] == 6'b111100) n_src++;
        chk("illegal_no_find_src", n_src, 0);
        chk("illegal_holds", illegal, 1'b1);

        // Abort 3 cycles after FIND-SRC, then restart
        clear_scn();
        vic_n = 1;
        vic[0] = 6'h1C;
        add_att(6'h1C, 6'h0B);
        build_expect();
        do_start(s);
        waited = 0;
        while (cmd_addr[7:2] != 6'b111100 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_find_src_seen", cmd_addr[7:2], 6'b111100);
        f = cyc;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_move_valid", move_valid, 1'b0);
        chk("abort_bus_nop", {cmd_addr, cmd_data}, 16'h0000);
        do_start(s);
        chk("restart_clears_illegal", illegal, 1'b0);
        walk(0, dc, fv);
        chk_bus("restart_en_all", 0, 16'hC000, f + RSP_LAT);

        // Randomized positions
        for (int r = 0; r < 8; r++) begin
            gen_random();
            build_expect();
            do_start(s);
            walk(0, dc, fv);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
